// File: rtl/challengeqsys_pixelmem_arbiter_if.sv
// Avalon-MM master-side bundle for one pixel memory client.
//   address/byteenable/read/write/writedata : driven by the master
//   waitrequest/readdata/readdatavalid      : driven by the arbiter
interface challengeqsys_pixelmem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/challengeqsys_pixelmem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port pixel memory.
// Ports:
//   clk, reset_n      : clock shared with the RAM, async active-low reset
//   m0, m1            : Avalon-MM masters (m0 = Nios data, m1 = pixel engine)
//   ram_*             : pixel memory s1 port; ram_readdata is valid the cycle
//                       after the address was presented
// One RAM access per cycle. Under contention the previous winner keeps the
// grant for at most MAX_HOLD consecutive cycles before the other master wins.
module challengeqsys_pixelmem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  challengeqsys_pixelmem_arbiter_if.slave m0,
  challengeqsys_pixelmem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  logic       last_grant_q, last_grant_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       rd_pending_q, rd_pending_d;
  logic       rd_owner_q, rd_owner_d;

  logic req0, req1;
  logic gnt0, gnt1;
  logic gnt_idx;
  logic sel_write;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign gnt_idx = gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      // Previous winner keeps the grant until its run reaches the limit.
      if (hold_cnt_q < HOLD_LIMIT) begin
        gnt0 = ~last_grant_q;
        gnt1 = last_grant_q;
      end else begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    if (req0 && req1) begin
      if (gnt_idx == last_grant_q) begin
        hold_cnt_d = (hold_cnt_q == 4'hF) ? hold_cnt_q : hold_cnt_q + 4'd1;
      end else begin
        last_grant_d = gnt_idx;
        hold_cnt_d   = 4'd1;
      end
    end else if (req0 || req1) begin
      last_grant_d = req1;
      hold_cnt_d   = 4'd0;
    end
  end

  assign sel_write    = gnt1 ? m1.write : m0.write;
  // Write wins over read, so only a pure read produces a return.
  assign rd_pending_d = (gnt0 | gnt1) & ~sel_write;
  assign rd_owner_d   = gnt_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Reset state makes the first contention go to m0.
      last_grant_q <= 1'b1;
      hold_cnt_q   <= HOLD_LIMIT;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    if (gnt0) begin
      ram_address    = m0.address;
      ram_byteenable = m0.byteenable;
      ram_write      = m0.write;
      ram_writedata  = m0.writedata;
    end else if (gnt1) begin
      ram_address    = m1.address;
      ram_byteenable = m1.byteenable;
      ram_write      = m1.write;
      ram_writedata  = m1.writedata;
    end
  end

  assign ram_chipselect = gnt0 | gnt1;
  assign ram_clken      = 1'b1;

  assign m0.waitrequest   = req0 & ~gnt0;
  assign m1.waitrequest   = req1 & ~gnt1;
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;
  assign m0.readdatavalid = rd_pending_q & ~rd_owner_q;
  assign m1.readdatavalid = rd_pending_q & rd_owner_q;

endmodule

// File: tb/tb_challengeqsys_pixelmem_arbiter.sv
// Randomized bench for the pixel memory arbiter: a behavioural RAM drives
// ram_readdata, and a reference model (grant rules, shadow memory, in-order
// return queue) predicts every waitrequest, RAM drive and read return.
module tb_challengeqsys_pixelmem_arbiter;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;
  localparam int DEPTH    = 8192;

  typedef struct {
    bit          owner;
    logic [31:0] data;
  } ret_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  challengeqsys_pixelmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  challengeqsys_pixelmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_writedata;
  logic              ram_clken;
  logic [31:0]       ram_readdata;

  challengeqsys_pixelmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata)
  );

  // Pixel memory: synchronous read, byte-lane write.
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] ram_q = '0;
  assign ram_readdata = ram_q;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_q <= ram_mem[ram_address];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  ret_t        exp_q[$];
  int          prev_winner;
  int          streak;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wait0, wait1;
  bit          track_wait = 0;
  logic [31:0] last_rd_data;

  // Stimulus for the next cycle.
  bit                r0, w0, r1, w1;
  logic [ADDR_W-1:0] a0, a1;
  logic [3:0]        be0, be1;
  logic [31:0]       d0, d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    prev_winner = 1;
    streak      = MAX_HOLD;
    exp_q.delete();
  endfunction

  task automatic idle();
    r0 = 0; w0 = 0; r1 = 0; w1 = 0;
    a0 = '0; a1 = '0; be0 = '0; be1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic step(input bit drop_rst = 1'b0);
    bit q0, q1, e0, e1, win;
    logic [31:0] merged;
    ret_t r;
    m0_if.read = r0; m0_if.write = w0; m0_if.address = a0;
    m0_if.byteenable = be0; m0_if.writedata = d0;
    m1_if.read = r1; m1_if.write = w1; m1_if.address = a1;
    m1_if.byteenable = be1; m1_if.writedata = d1;
    #1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    if (q0 && q1) win = (streak < MAX_HOLD) ? prev_winner[0] : ~prev_winner[0];
    else          win = q1;
    e0 = q0 && !win;
    e1 = q1 && win;
    chk("m0_waitrequest", 64'(m0_if.waitrequest), 64'(q0 & ~e0));
    chk("m1_waitrequest", 64'(m1_if.waitrequest), 64'(q1 & ~e1));
    chk("ram_chipselect", 64'(ram_chipselect), 64'(e0 | e1));
    chk("ram_write", 64'(ram_write), 64'(e0 ? w0 : e1 ? w1 : 1'b0));
    chk("ram_address", 64'(ram_address), 64'(e0 ? a0 : e1 ? a1 : '0));
    chk("ram_byteenable", 64'(ram_byteenable), 64'(e0 ? be0 : e1 ? be1 : 4'h0));
    chk("ram_writedata", 64'(ram_writedata), 64'(e0 ? d0 : e1 ? d1 : 32'h0));
    chk("ram_clken", 64'(ram_clken), 64'(1));
    if (track_wait) begin
      wait0 = (q0 && !e0) ? wait0 + 1 : 0;
      wait1 = (q1 && !e1) ? wait1 + 1 : 0;
      chk("m0_wait_bound", 64'(wait0 <= MAX_HOLD), 64'(1));
      chk("m1_wait_bound", 64'(wait1 <= MAX_HOLD), 64'(1));
    end
    if (reset_n) begin
      if (e0 || e1) begin
        if (win ? w1 : w0) begin
          merged = ref_mem[win ? a1 : a0];
          for (int b = 0; b < 4; b++)
            if ((win ? be1[b] : be0[b])) merged[b*8 +: 8] = (win ? d1[b*8 +: 8] : d0[b*8 +: 8]);
          ref_mem[win ? a1 : a0] = merged;
        end else begin
          r.owner = win;
          r.data  = ref_mem[win ? a1 : a0];
          exp_q.push_back(r);
        end
      end
      if (q0 && q1) begin
        if (int'(win) == prev_winner) streak = (streak == 15) ? 15 : streak + 1;
        else begin prev_winner = int'(win); streak = 1; end
      end else if (q0 || q1) begin
        prev_winner = int'(win);
        streak = 0;
      end
    end
    if (drop_rst) begin
      #2;
      reset_n = 1'b0;
      model_reset();
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("m0_readdatavalid", 64'(m0_if.readdatavalid), 64'(!r.owner));
      chk("m1_readdatavalid", 64'(m1_if.readdatavalid), 64'(r.owner));
      last_rd_data = r.owner ? m1_if.readdata : m0_if.readdata;
      chk("readdata", 64'(last_rd_data), 64'(r.data));
    end else begin
      chk("m0_readdatavalid_idle", 64'(m0_if.readdatavalid), 64'(0));
      chk("m1_readdatavalid_idle", 64'(m1_if.readdatavalid), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    model_reset();
    wait0 = 0; wait1 = 0;
    idle();
    @(posedge clk); #1;
    // Held in reset: no returns, and a contention still resolves to m0.
    step(); step();
    r0 = 1; r1 = 1; a0 = 13'h5; a1 = 13'h6;
    step();
    idle();
    reset_n = 1'b1;
    repeat (3) step();

    // Simultaneous reads: m0 first, m1 follows.
    r0 = 1; a0 = 13'h0010; r1 = 1; a1 = 13'h0020;
    step();
    r0 = 0;
    for (int k = 0; k < 4 && r1; k++) begin
      step();
      if (!m1_if.waitrequest) r1 = 0;
    end
    idle(); step();

    // Full-word write, readback, then partial-lane write and readback.
    w0 = 1; a0 = 13'h1FFF; be0 = 4'hF; d0 = 32'hDEADBEEF; step();
    idle(); r0 = 1; a0 = 13'h1FFF; step();
    chk("full_write_readback", 64'(last_rd_data), 64'(32'hDEADBEEF));
    idle(); w0 = 1; a0 = 13'h1FFF; be0 = 4'h3; d0 = 32'h12345678; step();
    idle(); r0 = 1; a0 = 13'h1FFF; step();
    chk("partial_write_readback", 64'(last_rd_data), 64'(32'hDEAD5678));
    idle(); step();

    // Sustained contention.
    track_wait = 1; wait0 = 0; wait1 = 0;
    for (int k = 0; k < 20; k++) begin
      r0 = 1; r1 = 1;
      a0 = 13'($urandom_range(0, DEPTH - 1));
      a1 = 13'($urandom_range(0, DEPTH - 1));
      step();
    end
    track_wait = 0;
    idle(); step();

    // m1 streaming with m0 idle.
    for (int k = 0; k < 256; k++) begin
      r1 = 1; a1 = 13'(k);
      step();
    end
    idle(); step();

    // Reset right after a granted m1 read drops the return.
    r1 = 1; a1 = 13'h0042; step(1'b1);
    idle();
    reset_n = 1'b1;
    r0 = 1; r1 = 1; a0 = 13'h0007; a1 = 13'h0008;
    step();
    idle(); step(); step();

    // Read and write together is a write.
    r0 = 1; w0 = 1; a0 = 13'h0100; be0 = 4'hF; d0 = 32'hA5A5A5A5; step();
    idle(); r0 = 1; a0 = 13'h0100; step();
    chk("rw_as_write_readback", 64'(last_rd_data), 64'(32'hA5A5A5A5));
    idle(); step();

    // Random mixed traffic on a small address window.
    track_wait = 1; wait0 = 0; wait1 = 0;
    for (int k = 0; k < 400; k++) begin
      r0 = bit'($urandom_range(0, 1)); w0 = ($urandom_range(0, 3) == 0);
      r1 = bit'($urandom_range(0, 1)); w1 = ($urandom_range(0, 3) == 0);
      a0 = 13'($urandom_range(0, 15)); a1 = 13'($urandom_range(0, 15));
      be0 = 4'($urandom); be1 = 4'($urandom);
      d0 = $urandom; d1 = $urandom;
      step();
    end
    track_wait = 0;
    idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/challengeqsys_pixelmem_arbiter.md
# challengeqsys_pixelmem_arbiter

Two-master arbiter that shares the single-port 8192x32 pixel memory between two Avalon-MM masters. m0 is the Nios II data master path and m1 is the pixel-processing/scan-out engine. The block sits between both masters and the pixel memory's s1 port. It issues at most one RAM access per cycle, with bounded-hold round-robin fairness, and routes the 1-cycle read return back to the correct master with `readdatavalid`.

## Interface
Parameters:
- `ADDR_W`, 13: word address width; must match pixel memory depth 8192.
- `DATA_W`, 32: data width; byteenable width is DATA_W/8.
- `MAX_HOLD`, 4: maximum consecutive contended grants to one master, range 1..15.

Ports:
- `clk`  in  1: single clock, shared with the pixel memory.
- `reset_n`  in  1: asynchronous, active-low reset.
- `m0_address`, `m1_address`  in  ADDR_W: word address.
- `m0_byteenable`, `m1_byteenable`  in  DATA_W/8: byte lanes for writes.
- `m0_read`, `m1_read`  in  1: read request.
- `m0_write`, `m1_write`  in  1: write request; wins over read if both are high.
- `m0_writedata`, `m1_writedata`  in  DATA_W: write data.
- `m0_waitrequest`, `m1_waitrequest`  out  1: request stalled this cycle.
- `m0_readdata`, `m1_readdata`  out  DATA_W: read return data.
- `m0_readdatavalid`, `m1_readdatavalid`  out  1: read return strobe.
- `ram_address`  out  ADDR_W: to pixel memory.
- `ram_byteenable`  out  DATA_W/8: to pixel memory.
- `ram_chipselect`  out  1: to pixel memory.
- `ram_write`  out  1: to pixel memory.
- `ram_writedata`  out  DATA_W: to pixel memory.
- `ram_clken`  out  1: tied to 1.
- `ram_readdata`  in  DATA_W: from pixel memory (unregistered q, valid the cycle after the address).

## Operation
- req_i = mi_read | mi_write. The grant is combinational from req0, req1 and state (`last_grant`, `hold_cnt`[3:0]).
- Grant rules:
  - Only one master requesting: that master is granted.
  - Both requesting: if `hold_cnt < MAX_HOLD`, grant `last_grant`. Otherwise grant the other master.
- State update each clock:
  - No request: `last_grant` and `hold_cnt` hold.
  - Single request: `last_grant` <= requester, `hold_cnt` <= 0.
  - Contention with the same master re-granted: `hold_cnt` <= `hold_cnt` + 1 (saturating at 15).
  - Contention with a switch: `last_grant` <= new master, `hold_cnt` <= 1.
- mi_waitrequest = req_i & ~grant_i. A non-requesting master sees 0.
- RAM drive:
  - `ram_chipselect` = grant0 | grant1.
  - Address, byteenable, writedata and write come from the granted master.
  - `ram_write` = granted master's write.
  - With no grant, `ram_address` = 0, `ram_byteenable` = 0, `ram_write` = 0, `ram_writedata` = 0.
- Read return:
  - On a granted read (not write), register `rd_pending` = 1 and `rd_owner` = granted index.
  - Next cycle, `m<rd_owner>_readdatavalid` = 1.
  - Both `mi_readdata` are wired to `ram_readdata`.
- Back-to-back reads from either master are accepted every cycle. Returns stay strictly in order, one per cycle.
- Writes produce no return.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `last_grant` = 1, `hold_cnt` = MAX_HOLD, so the first contention goes to m0.
  - `rd_pending` = 0, and both readdatavalid = 0.
  - Combinational outputs follow their inputs with the reset state.
- Read latency: request accepted in cycle t (waitrequest low) -> readdatavalid and data in cycle t+1.
- Write: committed at the clock edge ending the accepted cycle. A read of the same address granted in t+1 returns the new data in t+2.
- Contention with MAX_HOLD=N: the holder gets at most N consecutive contended cycles, then the other master gets the grant.
- Reset asserted with a read pending: the return is dropped and no readdatavalid is issued after reset release.
- Requests during reset: waitrequest follows the grant rules, but no state advances until `reset_n` is high.

## Test plan
- Reset release, idle cycles, then m0 reads addr 0x0010 and m1 reads 0x0020 in the same cycle:
  - m0 granted first (waitrequest0=0, waitrequest1=1).
  - m0_readdatavalid next cycle with mem[0x10].
  - m1 granted next cycle and receives mem[0x20] one cycle later.
- m0 writes 0xDEADBEEF to 0x1FFF with byteenable 0xF, then reads 0x1FFF next cycle -> readdatavalid two cycles after the write with 0xDEADBEEF. Repeat with byteenable 0x3 writing 0x12345678 -> readback 0xDEAD5678.
- Both masters hold read requests continuously for 20 cycles, MAX_HOLD=4:
  - After m0's first contended grant, grants alternate in runs of 4.
  - No master waits more than 4 cycles.
  - Each readdatavalid pulse lands on the correct master in issue order.
- Single master streaming: m1 reads 0x0000..0x00FF back-to-back with m0 idle -> zero waitrequest cycles and 256 consecutive readdatavalid pulses, data = mem[i].
- `reset_n` pulled low for 1 cycle right after a granted m1 read -> no m1_readdatavalid, both strobes 0. The next contended request goes to m0.
- m0 asserts read and write together to 0x0100 with writedata 0xA5A5A5A5 -> treated as a write: `ram_write`=1 and no readdatavalid.
